// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus port: packet address extraction and sticky error layout.
package bus_pkg;

   localparam int              PCKG_SZ_DFLT = 16;
   localparam int              ADDR_W       = 8;
   localparam int              PKT_MAX      = 64;
   localparam logic [ADDR_W-1:0] BROADCAST  = 8'hFF;

   typedef struct packed {
      logic misaddr;
      logic tx_underflow;
      logic tx_overflow;
   } err_flags_t;

   // Destination address lives in the top ADDR_W bits of a packet that is sz bits wide.
   function automatic logic [ADDR_W-1:0] addr_of(input logic [PKT_MAX-1:0] pkt, input int sz);
      logic [PKT_MAX-1:0] w_shifted;
      w_shifted = pkt >> (sz - ADDR_W);
      return w_shifted[ADDR_W-1:0];
   endfunction

endpackage

// File: rtl/bus_sync_fifo.sv
// First-word fall-through FIFO; head is a register so it holds its last value when the FIFO drains.
// Latency 1 clk write-to-visible; a write while full is ignored unless a read completes the same cycle.
module bus_sync_fifo #(
   parameter  int width = 16,
   parameter  int depth = 8,
   localparam int AW    = $clog2(depth),
   localparam int CW    = $clog2(depth + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr,
   input  logic [width-1:0] i_wr_dat,
   input  logic             i_rd,
   output logic [width-1:0] o_rd_dat,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);

   localparam logic [CW-1:0] FULL_CNT = CW'(depth);

   logic [width-1:0] r_mem [depth];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [width-1:0] r_dout;
   logic             w_wr;
   logic             w_rd;
   logic [AW-1:0]    w_rd_nxt;

   assign o_full   = (r_count == FULL_CNT);
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_rd_dat = r_dout;

   assign w_rd     = i_rd && !o_empty;
   assign w_wr     = i_wr && (!o_full || w_rd);
   assign w_rd_nxt = r_rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= w_rd_nxt;
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // New head comes from the write port when the FIFO is (or is about to be) empty.
         if (w_wr && (o_empty || (w_rd && r_count == CW'(1))))
            r_dout <= i_wr_dat;
         else if (w_rd && r_count > CW'(1))
            r_dout <= r_mem[w_rd_nxt];
      end
   end

endmodule

// File: rtl/bus_port_fifo.sv
// Per-driver bus port: TX queue toward the arbiter, address-filtered RX queue, sticky errors, RX drop count.
// Latency 1 clk tx_wr->pndng and push->!rx_empty; full FIFOs drop new packets and flag/count the loss.
module bus_port_fifo import bus_pkg::*; #(
   parameter  int                pckg_sz   = PCKG_SZ_DFLT,
   parameter  int                depth     = 8,
   parameter  logic [ADDR_W-1:0] drvr_id   = 8'h00,
   parameter  logic [ADDR_W-1:0] broadcast = BROADCAST,
   localparam int                CW        = $clog2(depth + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tx_wr,
   input  logic [pckg_sz-1:0] tx_data,
   output logic               tx_full,
   output logic [CW-1:0]      tx_count,
   output logic               pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic               pop,
   input  logic               push,
   input  logic [pckg_sz-1:0] D_push,
   input  logic               rx_rd,
   output logic [pckg_sz-1:0] rx_data,
   output logic               rx_empty,
   output logic [7:0]         rx_drop,
   output logic [2:0]         err_flags
);

   localparam logic [CW-1:0] FULL_CNT = CW'(depth);

   logic              w_tx_empty;
   logic              w_rx_full;
   logic [CW-1:0]     w_rx_cnt;
   logic [ADDR_W-1:0] w_dest;
   logic              w_addr_ok;
   logic              w_rx_wr;
   logic              w_rx_lost;
   logic [7:0]        r_rx_drop;
   err_flags_t        r_err;

   assign w_dest    = addr_of(PKT_MAX'(D_push), pckg_sz);
   assign w_addr_ok = (w_dest == drvr_id) || (w_dest == broadcast);
   assign w_rx_wr   = push && w_addr_ok;
   // A read on a full RX frees the slot in the same cycle, so only a full FIFO without rx_rd loses data.
   assign w_rx_lost = w_rx_wr && (w_rx_cnt == FULL_CNT) && !rx_rd;

   bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_tx_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .i_wr     (tx_wr),
      .i_wr_dat (tx_data),
      .i_rd     (pop),
      .o_rd_dat (D_pop),
      .o_full   (tx_full),
      .o_empty  (w_tx_empty),
      .o_count  (tx_count)
   );

   bus_sync_fifo #(.width(pckg_sz), .depth(depth)) u_rx_fifo (
      .clk      (clk),
      .rst_n    (reset),
      .i_wr     (w_rx_wr && (!w_rx_full || rx_rd)),
      .i_wr_dat (D_push),
      .i_rd     (rx_rd),
      .o_rd_dat (rx_data),
      .o_full   (w_rx_full),
      .o_empty  (rx_empty),
      .o_count  (w_rx_cnt)
   );

   assign pndng     = !w_tx_empty;
   assign rx_drop   = r_rx_drop;
   assign err_flags = r_err;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_drop <= '0;
         r_err     <= '0;
      end else begin
         if (w_rx_lost && r_rx_drop != 8'hFF) r_rx_drop <= r_rx_drop + 8'd1;
         if (tx_wr && tx_full && !pop)        r_err.tx_overflow  <= 1'b1;
         if (pop && w_tx_empty)               r_err.tx_underflow <= 1'b1;
         if (push && !w_addr_ok)              r_err.misaddr      <= 1'b1;
      end
   end

endmodule
